// File: rtl/tx_fifo_pkg.sv
// tx_fifo_pkg: shared helpers for the parametrised dual-clock TX FIFO.
// Pointer offset, Gray conversion and parameter legality checks.
package tx_fifo_pkg;

    localparam int PW_MAX = 10;

    typedef logic [PW_MAX-1:0] ptr_t;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Centres the 2*DEPTH used codes in the 2^(AW+1) Gray space so the wrap is a single-bit step.
    function automatic int ptr_offset(input int depth, input int aw);
        return ((1 << (aw + 1)) - 2 * depth) / 2;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b = g;
        for (int i = 1; i < PW_MAX; i++) b = b ^ (g >> i);
        return b;
    endfunction

    function automatic bit params_ok(input int width, input int depth, input int ready_th, input int sync_stages);
        return width >= 1 && width <= 128 && depth >= 4 && depth <= 256 && depth % 2 == 0 &&
               ready_th >= 1 && ready_th <= depth && sync_stages >= 2 && sync_stages <= 4;
    endfunction

endpackage

// File: rtl/tx_fifo_ptr_sync.sv
// tx_fifo_ptr_sync: multi-flop synchroniser for an offset Gray pointer, decoded back to binary.
module tx_fifo_ptr_sync import tx_fifo_pkg::*; #(
    parameter int PW = 5,
    parameter int SYNC_STAGES = 2,
    parameter int OFF = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [PW-1:0] gray_in,
    output logic [PW-1:0] bin_out
);

    localparam logic [PW-1:0] GRAY0 = PW'(bin2gray(ptr_t'(OFF)));

    logic [SYNC_STAGES-1:0][PW-1:0] sync_q;

    // Reset to the code of pointer 0, not to all-zeros, so the decode reads 0 out of reset.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) sync_q <= {SYNC_STAGES{GRAY0}};
        else sync_q <= {sync_q[SYNC_STAGES-2:0], gray_in};

    assign bin_out = PW'(gray2bin(ptr_t'(sync_q[SYNC_STAGES-1])) - ptr_t'(OFF));

endmodule

// File: rtl/tx_async_fifo_param.sv
// tx_async_fifo_param: dual-clock TX FIFO, any even depth, show-ahead registered read port.
// Optional sticky wr_overflow/rd_underflow flags when TX_FIFO_ERR_EN is defined.
module tx_async_fifo_param import tx_fifo_pkg::*; #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 12,
    parameter int READY_TH = 4,
    parameter int SYNC_STAGES = 2,
    localparam int AW = clog2(DEPTH)
) (
    input  logic             clk_wr,
    input  logic             reset_n_wr,
    input  logic             clk_rd,
    input  logic             reset_n_rd,
    input  logic             in_enable,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] data_wr,
    output logic             wr_ready,
    output logic [AW:0]      wr_level,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      rd_level
`ifdef TX_FIFO_ERR_EN
    ,
    output logic             wr_overflow,
    output logic             rd_underflow
`endif
);

    localparam int PW = AW + 1;
    localparam int OFF = ptr_offset(DEPTH, AW);
    localparam logic [AW:0] DEPTH_P = PW'(DEPTH);
    localparam logic [AW:0] LAST_P = PW'(2 * DEPTH - 1);
    localparam logic [AW:0] READY_P = PW'(READY_TH);
    localparam logic [AW+1:0] SPAN = (AW + 2)'(2 * DEPTH);
    localparam logic [AW:0] GRAY0 = PW'(bin2gray(ptr_t'(OFF)));

    if (!params_ok(WIDTH, DEPTH, READY_TH, SYNC_STAGES)) begin : g_bad_params
        $error("tx_async_fifo_param: illegal parameter set");
    end

    function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
        return (p == LAST_P) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [AW-1:0] ptr_idx(input logic [AW:0] p);
        return AW'((p >= DEPTH_P) ? p - DEPTH_P : p);
    endfunction

    function automatic logic [AW:0] ptr_dist(input logic [AW:0] a, input logic [AW:0] b);
        return PW'((a >= b) ? {1'b0, a} - {1'b0, b} : {1'b0, a} + SPAN - {1'b0, b});
    endfunction

    function automatic logic [AW:0] to_gray(input logic [AW:0] p);
        return PW'(bin2gray(ptr_t'(p) + ptr_t'(OFF)));
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wptr, wgray, rptr_sync, rptr, rgray, wptr_sync;
    logic full, push, empty, pop;

    assign wr_level = ptr_dist(wptr, rptr_sync);
    assign full = wr_level == DEPTH_P;
    assign push = in_enable & wr_en & ~full;

    always_ff @(posedge clk_wr or negedge reset_n_wr)
        if (!reset_n_wr) begin
            wptr <= '0;
            wgray <= GRAY0;
            wr_ready <= 1'b0;
        end else begin
            wgray <= to_gray(wptr);
            if (in_enable) begin
                if (push) wptr <= ptr_inc(wptr);
                wr_ready <= (DEPTH_P - wr_level) >= READY_P;
            end
        end

    // An entry is only written once the synced read pointer shows it free, so no reset is needed.
    always_ff @(posedge clk_wr)
        if (push) mem[ptr_idx(wptr)] <= data_wr;

    tx_fifo_ptr_sync #(.PW(PW), .SYNC_STAGES(SYNC_STAGES), .OFF(OFF)) u_rsync (
        .clk(clk_wr), .reset_n(reset_n_wr), .gray_in(rgray), .bin_out(rptr_sync)
    );

    tx_fifo_ptr_sync #(.PW(PW), .SYNC_STAGES(SYNC_STAGES), .OFF(OFF)) u_wsync (
        .clk(clk_rd), .reset_n(reset_n_rd), .gray_in(wgray), .bin_out(wptr_sync)
    );

    assign empty = rptr == wptr_sync;
    assign pop = in_enable & ~empty & (~rd_valid | rd_ready);
    assign rd_level = ptr_dist(wptr_sync, rptr) + PW'(rd_valid);

    always_ff @(posedge clk_rd or negedge reset_n_rd)
        if (!reset_n_rd) begin
            rptr <= '0;
            rgray <= GRAY0;
            rd_valid <= 1'b0;
            rd_data <= '0;
        end else begin
            rgray <= to_gray(rptr);
            if (pop) begin
                rptr <= ptr_inc(rptr);
                rd_valid <= 1'b1;
                rd_data <= mem[ptr_idx(rptr)];
            end else if (in_enable & rd_ready) rd_valid <= 1'b0;
        end

`ifdef TX_FIFO_ERR_EN
    always_ff @(posedge clk_wr or negedge reset_n_wr)
        if (!reset_n_wr) wr_overflow <= 1'b0;
        else if (in_enable & wr_en & full) wr_overflow <= 1'b1;

    always_ff @(posedge clk_rd or negedge reset_n_rd)
        if (!reset_n_rd) rd_underflow <= 1'b0;
        else if (in_enable & rd_ready & ~rd_valid) rd_underflow <= 1'b1;
`endif

endmodule
